// File: rtl/comb_div.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | comb_div : 8-bit by 4-bit unsigned restoring divider, one bit per clock   |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module comb_div (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_start,
   input  logic [7:0] i_dividend,
   input  logic [3:0] i_divisor,
   output logic       o_busy,
   output logic       o_done,
   output logic [7:0] o_quotient,
   output logic [3:0] o_remainder,
   output logic       o_div_by_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_dvd;      // dividend shifts out MSB-first, quotient shifts in
   logic [3:0] r_dvs;
   logic [3:0] r_part;
   logic [2:0] r_cnt;
   logic [7:0] r_quot;
   logic [3:0] r_rem;
   logic       r_dbz;

   logic [4:0] w_trial;
   logic       w_ge;
   logic [3:0] w_part_nxt;
   logic       w_accept;
   logic       w_last;

   // Kept remainder is always below the divisor, so the 4-bit difference is exact.
   assign w_trial    = {r_part, r_dvd[7]};
   assign w_ge       = (w_trial >= {1'b0, r_dvs});
   assign w_part_nxt = w_ge ? (w_trial[3:0] - r_dvs) : w_trial[3:0];
   assign w_accept   = (r_state == S_IDLE) && i_start;
   assign w_last     = (r_cnt == 3'd7);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt = (i_divisor == 4'd0) ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dvd  <= 8'd0;
         r_dvs  <= 4'd0;
         r_part <= 4'd0;
         r_cnt  <= 3'd0;
         r_quot <= 8'd0;
         r_rem  <= 4'd0;
         r_dbz  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_dvd  <= i_dividend;
            r_dvs  <= i_divisor;
            r_part <= 4'd0;
            r_cnt  <= 3'd0;
            if (i_divisor == 4'd0) begin
               r_quot <= 8'hFF;
               r_rem  <= i_dividend[3:0];
               r_dbz  <= 1'b1;
            end
         end else if (r_state == S_CALC) begin
            r_dvd  <= {r_dvd[6:0], w_ge};
            r_part <= w_part_nxt;
            r_cnt  <= r_cnt + 3'd1;
            if (w_last) begin
               r_quot <= {r_dvd[6:0], w_ge};
               r_rem  <= w_part_nxt;
               r_dbz  <= 1'b0;
            end
         end
      end
   end

   assign o_busy        = (r_state != S_IDLE);
   assign o_done        = (r_state == S_DONE);
   assign o_quotient    = r_quot;
   assign o_remainder   = r_rem;
   assign o_div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_comb_div.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_comb_div : self-checking bench for comb_div against an arithmetic model|
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_comb_div;

   logic       clk;
   logic       rst_n;
   logic       i_start;
   logic [7:0] i_dividend;
   logic [3:0] i_divisor;
   logic       o_busy;
   logic       o_done;
   logic [7:0] o_quotient;
   logic [3:0] o_remainder;
   logic       o_div_by_zero;

   int n_tests = 0;
   int n_fail  = 0;

   comb_div dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_start       (i_start),
      .i_dividend    (i_dividend),
      .i_divisor     (i_divisor),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_quotient    (o_quotient),
      .o_remainder   (o_remainder),
      .o_div_by_zero (o_div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ref_q(input int dvd, input int dvs);
      return (dvs == 0) ? 8'hFF : 8'(dvd / dvs);
   endfunction

   function automatic logic [3:0] ref_r(input int dvd, input int dvs);
      return (dvs == 0) ? 4'(dvd % 16) : 4'(dvd % dvs);
   endfunction

   // Launch one operation from IDLE; operands are scrambled after acceptance.
   // lat = edges after the accepting edge until done is seen, -1 on timeout.
   task automatic launch(input logic [7:0] dvd, input logic [3:0] dvs, output int lat);
      i_dividend = dvd;
      i_divisor  = dvs;
      i_start    = 1'b1;
      @(posedge clk); #1;
      i_start    = 1'b0;
      i_dividend = 8'($urandom);
      i_divisor  = 4'($urandom);
      lat = 0;
      while (!o_done && lat < 20) begin
         @(posedge clk); #1;
         i_dividend = 8'($urandom);
         i_divisor  = 4'($urandom);
         lat++;
      end
      if (!o_done) lat = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_start = 1'b1; i_dividend = 8'd77; i_divisor = 4'd3;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({o_busy, o_done, o_quotient, o_remainder, o_div_by_zero} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
                  o_busy, o_done, o_quotient, o_remainder, o_div_by_zero);
      end
      i_start = 1'b0;
      rst_n   = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_after_release: got busy=%b, want 0", o_busy);
      end
   endtask

   task automatic test_basic();
      int lat;
      launch(8'd200, 4'd7, lat);
      n_tests++;
      if (lat !== 8) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d edges, want 8", lat);
      end
      n_tests++;
      if (o_quotient !== 8'd28 || o_remainder !== 4'd4 || o_div_by_zero !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_200_7: got q=%0d r=%0d dz=%b, want q=28 r=4 dz=0",
                  o_quotient, o_remainder, o_div_by_zero);
      end
      @(posedge clk); #1;
      n_tests++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_quotient !== 8'd28 || o_remainder !== 4'd4) begin
         n_fail++;
         $display("FAIL basic_after_done: got done=%b busy=%b q=%0d r=%0d, want 0 0 28 4",
                  o_done, o_busy, o_quotient, o_remainder);
      end
   endtask

   task automatic test_div_zero();
      int lat;
      launch(8'd13, 4'd0, lat);
      n_tests++;
      if (lat !== 0) begin
         n_fail++;
         $display("FAIL dz_latency: got %0d edges, want 0", lat);
      end
      n_tests++;
      if (o_quotient !== 8'hFF || o_remainder !== 4'hD || o_div_by_zero !== 1'b1 || o_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL dz_13_0: got q=%h r=%h dz=%b busy=%b, want q=ff r=d dz=1 busy=1",
                  o_quotient, o_remainder, o_div_by_zero, o_busy);
      end
      @(posedge clk); #1;
      n_tests++;
      if (o_done !== 1'b0 || o_div_by_zero !== 1'b1) begin
         n_fail++;
         $display("FAIL dz_hold: got done=%b dz=%b, want done=0 dz=1", o_done, o_div_by_zero);
      end
   endtask

   task automatic test_exact();
      int lat;
      launch(8'd225, 4'd15, lat);
      n_tests++;
      if (lat !== 8 || o_quotient !== 8'd15 || o_remainder !== 4'd0 || o_div_by_zero !== 1'b0) begin
         n_fail++;
         $display("FAIL exact_225_15: got lat=%0d q=%0d r=%0d dz=%b, want lat=8 q=15 r=0 dz=0",
                  lat, o_quotient, o_remainder, o_div_by_zero);
      end
      @(posedge clk); #1;
      launch(8'd255, 4'd1, lat);
      n_tests++;
      if (lat !== 8 || o_quotient !== 8'd255 || o_remainder !== 4'd0) begin
         n_fail++;
         $display("FAIL exact_255_1: got lat=%0d q=%0d r=%0d, want lat=8 q=255 r=0",
                  lat, o_quotient, o_remainder);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_ignore_start();
      int  cyc;
      bit  busy_ok;
      i_dividend = 8'd200; i_divisor = 4'd7; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      busy_ok = 1'b1;
      cyc = 0;
      while (!o_done && cyc < 20) begin
         if (!o_busy) busy_ok = 1'b0;
         // Re-pulse start with different operands in the middle of CALC.
         i_start    = (cyc == 3);
         i_dividend = 8'd17;
         i_divisor  = 4'd2;
         @(posedge clk); #1;
         cyc++;
      end
      n_tests++;
      if (!busy_ok || cyc !== 8) begin
         n_fail++;
         $display("FAIL ignore_busy: got busy_ok=%b lat=%0d, want busy_ok=1 lat=8", busy_ok, cyc);
      end
      n_tests++;
      if (o_quotient !== 8'd28 || o_remainder !== 4'd4) begin
         n_fail++;
         $display("FAIL ignore_result: got q=%0d r=%0d, want q=28 r=4", o_quotient, o_remainder);
      end
      // Start during the DONE cycle is also ignored.
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      n_tests++;
      if (o_busy !== 1'b0 || o_quotient !== 8'd28) begin
         n_fail++;
         $display("FAIL ignore_in_done: got busy=%b q=%0d, want busy=0 q=28", o_busy, o_quotient);
      end
   endtask

   task automatic test_reset_mid();
      int  lat;
      bit  saw_done;
      i_dividend = 8'd50; i_divisor = 4'd3; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({o_busy, o_done, o_quotient, o_remainder, o_div_by_zero} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_mid_immediate: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
                  o_busy, o_done, o_quotient, o_remainder, o_div_by_zero);
      end
      saw_done = 1'b0;
      i_start = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         if (o_done || o_busy) saw_done = 1'b1;
      end
      i_start = 1'b0;
      rst_n   = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (o_done) saw_done = 1'b1;
      end
      n_tests++;
      if (saw_done) begin
         n_fail++;
         $display("FAIL reset_mid_no_done: got activity after reset=1, want 0");
      end
      launch(8'd100, 4'd9, lat);
      n_tests++;
      if (lat !== 8 || o_quotient !== 8'd11 || o_remainder !== 4'd1) begin
         n_fail++;
         $display("FAIL reset_mid_100_9: got lat=%0d q=%0d r=%0d, want lat=8 q=11 r=1",
                  lat, o_quotient, o_remainder);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int         lat;
      logic [7:0] dvd;
      logic [3:0] dvs;
      for (int n = 0; n < 40; n++) begin
         dvd = 8'($urandom);
         dvs = 4'($urandom);
         launch(dvd, dvs, lat);
         n_tests++;
         if (lat !== ((dvs == 0) ? 0 : 8) || o_quotient !== ref_q(dvd, dvs) ||
             o_remainder !== ref_r(dvd, dvs) || o_div_by_zero !== (dvs == 0)) begin
            n_fail++;
            $display("FAIL random_%0d_%0d: got lat=%0d q=%0d r=%0d dz=%b, want q=%0d r=%0d",
                     dvd, dvs, lat, o_quotient, o_remainder, o_div_by_zero,
                     ref_q(dvd, dvs), ref_r(dvd, dvs));
         end
         @(posedge clk); #1;
      end
   endtask

   // All pairs with start held high; each done-to-done gap reflects throughput.
   task automatic test_sweep();
      int  gap;
      int  want_gap;
      int  bad;
      int  dvd;
      int  dvs;
      bad = 0;
      i_start = 1'b1;
      for (int idx = 0; idx < 4096; idx++) begin
         dvd = idx % 256;
         dvs = idx / 256;
         i_dividend = 8'(dvd);
         i_divisor  = 4'(dvs);
         gap = 0;
         do begin
            @(posedge clk); #1;
            gap++;
         end while (!o_done && gap < 25);
         want_gap = (idx == 0) ? ((dvs == 0) ? 1 : 9) : ((dvs == 0) ? 2 : 10);
         if (!o_done || gap != want_gap || o_quotient !== ref_q(dvd, dvs) ||
             o_remainder !== ref_r(dvd, dvs) || o_div_by_zero !== (dvs == 0) ||
             (dvs != 0 && (int'(o_quotient) * dvs + int'(o_remainder) != dvd ||
                           int'(o_remainder) >= dvs))) begin
            bad++;
            if (bad <= 5)
               $display("FAIL sweep_%0d_%0d: got done=%b gap=%0d q=%0d r=%0d dz=%b, want gap=%0d q=%0d r=%0d",
                        dvd, dvs, o_done, gap, o_quotient, o_remainder, o_div_by_zero,
                        want_gap, ref_q(dvd, dvs), ref_r(dvd, dvs));
         end
      end
      i_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL sweep_total: got %0d bad pairs, want 0", bad);
      end
   endtask

   initial begin
      rst_n = 1'b0; i_start = 1'b0; i_dividend = 8'd0; i_divisor = 4'd0;
      #1;
      test_reset();
      test_basic();
      test_div_zero();
      test_exact();
      test_ignore_start();
      test_reset_mid();
      test_random();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
